// File: rtl/sram_bank_pkg.sv
// Shared defaults and response layout for the banked SRAM controller.
// Responses are stored as {write, err, data} in both the pend and skid stages.
package sram_bank_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_BANK_AW    = 13;
  localparam int unsigned DEF_BANK_SEL_W = 2;
  localparam int unsigned DEF_NUM_BANKS  = 4;

  // Metadata bits that sit above the data field of a stored response
  localparam int unsigned RSP_META_W = 2;

  typedef struct packed {
    logic write;
    logic err;
  } rsp_meta_t;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_bank_macro.sv
// Behavioural single-port SRAM macro: active-low select/write-enable, byte mask,
// registered read port that holds its last value while deselected.
module sram_bank_macro
  import sram_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned AW     = DEF_BANK_AW,
  localparam int unsigned BE_W  = be_width(DATA_W)
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic              web0,
  input  logic [AW-1:0]     addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0,
  input  logic [BE_W-1:0]   wmask0
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller: valid/ready request decode onto NUM_BANKS macros,
// one-cycle response with a one-entry skid register absorbing back-pressure.
module sram_bank_ctrl
  import sram_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BANK_AW    = DEF_BANK_AW,
  parameter int unsigned BANK_SEL_W = DEF_BANK_SEL_W,
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  localparam int unsigned ADDR_W    = BANK_AW + BANK_SEL_W,
  localparam int unsigned BE_W      = be_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_write_o,
  output logic              rsp_err_o
);

  localparam int unsigned RSP_W = RSP_META_W + DATA_W;
  localparam logic [BANK_SEL_W:0] BANK_LIMIT = (BANK_SEL_W+1)'(NUM_BANKS);

  logic                  rst_released;
  logic                  accept;
  logic [BANK_SEL_W-1:0] req_bank;
  logic                  req_in_range;

  logic                  pend_valid;
  logic [BANK_SEL_W-1:0] pend_bank;
  rsp_meta_t             pend_meta;
  logic [DATA_W-1:0]     pend_data;

  logic                  skid_valid;
  logic [RSP_W-1:0]      skid_q;

  logic [NUM_BANKS-1:0]  csb;
  logic [DATA_W-1:0]     dout [NUM_BANKS];

  // Request decode
  assign req_ready_o  = rst_released & ~skid_valid;
  assign accept       = req_valid_i & req_ready_o;
  assign req_bank     = req_addr_i[ADDR_W-1 -: BANK_SEL_W];
  assign req_in_range = {1'b0, req_bank} < BANK_LIMIT;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign csb[b] = ~(accept & req_in_range & (req_bank == BANK_SEL_W'(b)));

    sram_bank_macro #(
      .DATA_W (DATA_W),
      .AW     (BANK_AW)
    ) u_macro (
      .clk0   (clk_i),
      .csb0   (csb[b]),
      .web0   (~req_write_i),
      .addr0  (req_addr_i[BANK_AW-1:0]),
      .din0   (req_wdata_i),
      .dout0  (dout[b]),
      .wmask0 (req_be_i)
    );
  end

  // Read data of the pending entry; macro output is stable until the next select
  always_comb begin
    pend_data = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (!pend_meta.write && !pend_meta.err && (pend_bank == BANK_SEL_W'(b))) begin
        pend_data = dout[b];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_released <= 1'b0;
    end else begin
      rst_released <= 1'b1;
    end
  end

  // Pend stage: loaded on accept, otherwise retired unless held behind skid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_valid <= 1'b0;
      pend_bank  <= '0;
      pend_meta  <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_bank  <= req_bank;
      pend_meta  <= rsp_meta_t'{write: req_write_i, err: ~req_in_range};
    end else if (!skid_valid) begin
      pend_valid <= 1'b0;
    end
  end

  // Skid stage: captures a stalled pend response, drains when the bus takes it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (skid_valid) begin
      if (rsp_ready_i) skid_valid <= 1'b0;
    end else if (pend_valid && !rsp_ready_i) begin
      skid_valid <= 1'b1;
      skid_q     <= {pend_meta, pend_data};
    end
  end

  // Output mux, skid has priority to keep ordering
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_write_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = '0;
    if (skid_valid) begin
      rsp_valid_o = 1'b1;
      {rsp_write_o, rsp_err_o, rsp_rdata_o} = skid_q;
    end else if (pend_valid) begin
      rsp_valid_o = 1'b1;
      {rsp_write_o, rsp_err_o, rsp_rdata_o} = {pend_meta, pend_data};
    end
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl (3 populated banks): directed cases plus random
// traffic against an in-order response queue and a word-addressed memory model.
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        write;
    logic        err;
    logic        stalled;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mdl [int];
  logic        m_released;
  logic [14:0] pool [8];
  logic        acc;

  always #5 clk = ~clk;

  sram_bank_ctrl #(
    .DATA_W     (32),
    .BANK_AW    (13),
    .BANK_SEL_W (2),
    .NUM_BANKS  (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_write_o (rsp_write),
    .rsp_err_o   (rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // A response blocks new requests exactly when it was already refused once
  function automatic logic model_ready();
    return m_released && !(q.size() != 0 && q[0].stalled);
  endfunction

  task automatic check_outputs();
    logic has;
    has = (q.size() != 0);
    chk("rsp_valid", 32'(rsp_valid), 32'(has));
    chk("req_ready", 32'(req_ready), 32'(model_ready()));
    if (has) begin
      chk("rsp_rdata", rsp_rdata, q[0].data);
      chk("rsp_write", 32'(rsp_write), 32'(q[0].write));
      chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
    end
  endtask

  // One clock: check outputs, drive inputs, then advance the model over the coming edge
  task automatic cycle(input logic v, input logic w, input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic rdy, output logic accepted);
    logic [1:0]  bank;
    logic        in_rng;
    logic [2:0]  exp_csb;
    logic [31:0] m;
    ent_t        e;
    @(negedge clk);
    check_outputs();
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rdy;
    #1;
    bank     = a[14:13];
    in_rng   = (bank < 2'd3);
    accepted = v && model_ready();
    exp_csb  = 3'b111;
    if (accepted && in_rng) exp_csb = ~(3'd1 << bank);
    chk("csb", 32'(dut.csb), 32'(exp_csb));
    if (rst_n) begin
      if (q.size() != 0) begin
        if (rdy) void'(q.pop_front());
        else begin
          e = q[0]; e.stalled = 1'b1; q[0] = e;
        end
      end
      if (accepted) begin
        e.write = w; e.err = !in_rng; e.stalled = 1'b0; e.data = 32'h0;
        if (in_rng) begin
          m = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
          if (w) begin
            for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = d[i*8 +: 8];
            mdl[int'(a)] = m;
          end else begin
            e.data = m;
          end
        end
        q.push_back(e);
      end
      m_released = 1'b1;
    end
  endtask

  task automatic send(input logic w, input logic [14:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rdy);
    logic ok;
    int   n;
    ok = 1'b0; n = 0;
    do begin
      cycle(1'b1, w, a, d, be, rdy, ok);
      n++;
    end while (!ok && n < 50);
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 15'h0, 32'h0, 4'h0, rdy, dummy);
  endtask

  // Hand-computed expectation for the response presented after the next edge
  task automatic expect_lit(input string nm, input logic [31:0] d, input logic w, input logic e);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_rdata"}, rsp_rdata, d);
    chk({nm, "_write"}, 32'(rsp_write), 32'(w));
    chk({nm, "_err"}, 32'(rsp_err), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0; m_released = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    pool = '{15'h0010, 15'h2005, 15'h4000, 15'h0000, 15'h2000, 15'h1FFF, 15'h5ABC, 15'h6000};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_write", 32'(rsp_write), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1; m_released = 1'b1;

    // Write then read
    send(1'b1, 15'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
    expect_lit("wr_rsp", 32'h0, 1'b1, 1'b0);
    send(1'b0, 15'h0010, 32'h0, 4'h0, 1'b1);
    expect_lit("rd_dead", 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte mask merge
    send(1'b1, 15'h2005, 32'hAABBCCDD, 4'hF, 1'b1);
    send(1'b1, 15'h2005, 32'h11223344, 4'b0101, 1'b1);
    send(1'b0, 15'h2005, 32'h0, 4'h0, 1'b1);
    expect_lit("bytemask", 32'hAA22CC44, 1'b0, 1'b0);

    // Bank decode and out-of-range bank
    send(1'b1, 15'h0000, 32'h0B0B0000, 4'hF, 1'b1);
    send(1'b1, 15'h2000, 32'h1B1B1111, 4'hF, 1'b1);
    send(1'b1, 15'h4000, 32'h2B2B2222, 4'hF, 1'b1);
    send(1'b1, 15'h6000, 32'h3B3B3333, 4'hF, 1'b1);
    expect_lit("err_wr", 32'h0, 1'b1, 1'b1);
    send(1'b0, 15'h0000, 32'h0, 4'h0, 1'b1);
    send(1'b0, 15'h2000, 32'h0, 4'h0, 1'b1);
    send(1'b0, 15'h4000, 32'h0, 4'h0, 1'b1);
    expect_lit("bank2", 32'h2B2B2222, 1'b0, 1'b0);
    send(1'b0, 15'h6000, 32'h0, 4'h0, 1'b1);
    expect_lit("err_rd", 32'h0, 1'b0, 1'b1);

    // Zero byte-enable write leaves data intact
    send(1'b1, 15'h0000, 32'hFFFFFFFF, 4'h0, 1'b1);
    send(1'b0, 15'h0000, 32'h0, 4'h0, 1'b1);
    expect_lit("be_zero", 32'h0B0B0000, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Back-pressure: four reads, response ready low for three cycles
    cycle(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 15'h2000, 32'h0, 4'h0, 1'b0, acc);
    @(posedge clk);
    #1;
    chk("bp_ready_drop", 32'(req_ready), 32'd0);
    cycle(1'b1, 1'b0, 15'h4000, 32'h0, 4'h0, 1'b0, acc);
    send(1'b0, 15'h4000, 32'h0, 4'h0, 1'b1);
    send(1'b0, 15'h0010, 32'h0, 4'h0, 1'b1);
    idle(4, 1'b1);

    // Asynchronous reset while the skid register holds a response
    cycle(1'b1, 1'b0, 15'h2000, 32'h0, 4'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 15'h4000, 32'h0, 4'h0, 1'b0, acc);
    @(posedge clk);
    #2;
    chk("pre_rst_stall", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    q.delete();
    m_released = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1; m_released = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    send(1'b0, 15'h0010, 32'h0, 4'h0, 1'b1);
    expect_lit("post_rst_rd", 32'hDEADBEEF, 1'b0, 1'b0);

    // Random traffic over a small address pool
    send(1'b1, 15'h1FFF, 32'h5EED0001, 4'hF, 1'b1);
    send(1'b1, 15'h5ABC, 32'h5EED0002, 4'hF, 1'b1);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, 1'($urandom % 2), pool[$urandom_range(0, 7)], $urandom,
            4'($urandom), ($urandom % 3) != 0, acc);
    end
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
        idle(1, 1'b1);
        n++;
      end
    end
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
